packet_parser: RTL
==================

PACKET_PARSER -- requirements
Module: packet_parser

Interface
REQ-001 The module SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WORD_WIDTH, default 16, SHALL set the stream and field word width.
REQ-003 Parameter MAX_KCH, default 8, SHALL set the known-CH buffer depth.
REQ-004 Parameter ACCEPT_MASK, default 8'b0000_0110, SHALL mark the accepted packet types; bit t accepts type t.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock.
REQ-006 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Port in_valid, input, 1 bit, SHALL flag a valid stream word.
REQ-008 Port in_data, input, WORD_WIDTH bits, SHALL carry the stream word.
REQ-009 Port in_last, input, 1 bit, SHALL mark the final word of a packet.
REQ-010 Port in_ready, output, 1 bit, SHALL show the parser can accept a word.
REQ-011 Port en, output, 1 bit, SHALL be the start pulse to the Q-table update stage.
REQ-012 Port done, input, 1 bit, SHALL be the completion from the Q-table update stage.
REQ-013 Port fPacketType, output, 3 bits, SHALL carry the header type.
REQ-014 Ports fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, output, WORD_WIDTH bits each, SHALL carry the parsed fields.
REQ-015 Port fKnownCHCount, output, WORD_WIDTH bits, SHALL carry the number of stored CH entries.
REQ-016 Port kch_sel, input, clog2(MAX_KCH) bits, SHALL select a CH entry.
REQ-017 Port fKnownCH, output, WORD_WIDTH bits, SHALL combinationally return buffer[kch_sel], or 0 if kch_sel >= fKnownCHCount.
REQ-018 Port drop_pulse, output, 1 bit, SHALL pulse once per dropped packet.
REQ-019 Port drop_count, output, 8 bits, SHALL count dropped packets and saturate at 255.

Function
REQ-020 A word SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-021 Packet format: word0 = header (type=[15:13], chCount=[7:0]); words 1-5 = SourceID, SourceHops, ClusterID, EnergyLeft, QValue; words 6..6+chCount-1 = CH IDs.
REQ-022 The FSM SHALL have these states: S_HDR, S_FIELDS, S_KCH, S_FLUSH, S_ISSUE, S_WAIT.
REQ-023 in_ready SHALL be 1 in S_HDR, S_FIELDS, S_KCH and S_FLUSH, and 0 in S_ISSUE and S_WAIT.
REQ-024 In S_HDR, a header transfer SHALL latch type and chCount, then move to S_FIELDS; a header with in_last=1 SHALL be dropped and the FSM SHALL stay in S_HDR.
REQ-025 In S_FIELDS, a 3-bit index SHALL store words 1-5 in order; after word 5 the FSM SHALL move to S_KCH if chCount>0, otherwise resolve end-of-packet.
REQ-026 In S_KCH, the buffer SHALL store the first min(chCount, MAX_KCH) entries; entries beyond MAX_KCH SHALL be discarded but still counted toward packet length.
REQ-027 fKnownCHCount SHALL equal min(chCount, MAX_KCH), zero-extended.
REQ-028 End-of-packet: if the last expected word has in_last=1, go to S_ISSUE; if not, go to S_FLUSH and discard words until in_last, then go to S_ISSUE.
REQ-029 Short packet: in_last on any word before the last expected word SHALL drop the packet, pulse drop_pulse for 1 cycle, increment drop_count and return to S_HDR.
REQ-030 Type filter: a complete packet whose ACCEPT_MASK[type]=0 SHALL be dropped at end-of-packet as in REQ-029 without entering S_ISSUE.
REQ-031 S_ISSUE SHALL assert en for exactly 1 cycle, on the cycle after the final word transfers, then move to S_WAIT.
REQ-032 All f* outputs and the CH buffer SHALL stay stable from the en cycle until done is sampled in S_WAIT.
REQ-033 done sampled high in S_WAIT SHALL return the FSM to S_HDR, with in_ready=1 on the next cycle; done in any other state SHALL be ignored.
REQ-034 Field registers SHALL update only while a packet is being parsed; a dropped packet MAY leave partial values, but en SHALL never assert for it.

Reset
REQ-035 rst=1 SHALL force S_HDR; in_ready=1 the following cycle; en=0; drop_pulse=0; drop_count=0; all f* registers, fKnownCHCount and the buffer =0.
REQ-036 Reset mid-packet or in S_WAIT SHALL discard the partial packet without pulsing en or drop_pulse; the first word after reset SHALL be treated as a header.

Verification
REQ-037 Header 16'h2002, fields 1,2,3,100,50, CH 7,9 with in_last on 9 -> en 1 cycle later; fPacketType=1; fKnownCHCount=2; kch_sel=1 gives fKnownCH=9; in_ready=0 until done.
REQ-038 Header 16'h200A (chCount=10, MAX_KCH=8) -> 8 entries stored, fKnownCHCount=8, en after the 16th word.
REQ-039 in_last on word 3 -> drop_pulse=1, drop_count=1, no en, next word parsed as a header.
REQ-040 Type 0 packet (16'h0000 plus 5 fields) -> dropped, drop_count increments, no en; 300 drops -> drop_count=255.
REQ-041 Two extra words after the last CH, in_last on the second -> en after that word, fields unchanged by the extra words.
REQ-042 rst in S_WAIT and mid-S_KCH -> all outputs 0, in_ready=1, no en or drop_pulse; the next packet parses correctly.

Source files
------------

// File: rtl/packet_parser.sv
// Stream parser: splits a header/field/known-CH packet into registers, drops short or
// filtered packets, and hands accepted ones to the Q-table stage with an en/done handshake.
module packet_parser #(
  parameter int         WORD_WIDTH  = 16,
  parameter int         MAX_KCH     = 8,
  parameter logic [7:0] ACCEPT_MASK = 8'b0000_0110
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WORD_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         en,
  input  logic                         done,
  output logic [2:0]                   fPacketType,
  output logic [WORD_WIDTH-1:0]        fSourceID,
  output logic [WORD_WIDTH-1:0]        fSourceHops,
  output logic [WORD_WIDTH-1:0]        fClusterID,
  output logic [WORD_WIDTH-1:0]        fEnergyLeft,
  output logic [WORD_WIDTH-1:0]        fQValue,
  output logic [WORD_WIDTH-1:0]        fKnownCHCount,
  input  logic [$clog2(MAX_KCH)-1:0]   kch_sel,
  output logic [WORD_WIDTH-1:0]        fKnownCH,
  output logic                         drop_pulse,
  output logic [7:0]                   drop_count
);

  localparam int SEL_W = $clog2(MAX_KCH);

  typedef enum logic [2:0] {S_HDR, S_FIELDS, S_KCH, S_FLUSH, S_ISSUE, S_WAIT} state_t;

  state_t                state_r;
  logic                  inReady_r, en_r, dropPulse_r;
  logic [7:0]            dropCount_r, chCount_r, kchIdx_r;
  logic [2:0]            fieldIdx_r, fPacketType_r;
  logic [WORD_WIDTH-1:0] fSourceID_r, fSourceHops_r, fClusterID_r, fEnergyLeft_r, fQValue_r;
  logic [WORD_WIDTH-1:0] fKnownCHCount_r;
  logic [WORD_WIDTH-1:0] kchBuf_r [MAX_KCH];

  logic                  xfer_s, lastExpected_s, accept_s, kchStore_s;
  logic                  shortDrop_s, complete_s, toFlush_s, dropNow_s, issueNow_s;
  logic [WORD_WIDTH-1:0] hdrKchCount_s, knownCH_s;

  // Transfer qualification and end-of-packet classification for the current word.
  always_comb begin
    xfer_s     = in_valid & inReady_r;
    accept_s   = ACCEPT_MASK[fPacketType_r];
    kchStore_s = ({1'b0, kchIdx_r} < 9'(MAX_KCH));
    case (state_r)
      S_FIELDS: lastExpected_s = (fieldIdx_r == 3'd4) && (chCount_r == 8'd0);
      S_KCH:    lastExpected_s = (kchIdx_r == (chCount_r - 8'd1));
      default:  lastExpected_s = 1'b0;
    endcase
    if ({1'b0, in_data[7:0]} > 9'(MAX_KCH)) begin
      hdrKchCount_s = WORD_WIDTH'(MAX_KCH);
    end else begin
      hdrKchCount_s = WORD_WIDTH'(in_data[7:0]);
    end
    // A header carrying in_last is also a short packet, since lastExpected_s is 0 there.
    if ((state_r == S_HDR) || (state_r == S_FIELDS) || (state_r == S_KCH)) begin
      shortDrop_s = xfer_s & in_last & ~lastExpected_s;
    end else begin
      shortDrop_s = 1'b0;
    end
    complete_s = xfer_s & in_last & (lastExpected_s | (state_r == S_FLUSH));
    toFlush_s  = xfer_s & ~in_last & lastExpected_s;
    dropNow_s  = shortDrop_s | (complete_s & ~accept_s);
    issueNow_s = complete_s & accept_s;
  end

  // Known-CH read port; entries past the stored count read as zero.
  always_comb begin
    if (WORD_WIDTH'(kch_sel) < fKnownCHCount_r) begin
      knownCH_s = kchBuf_r[kch_sel];
    end else begin
      knownCH_s = {WORD_WIDTH{1'b0}};
    end
  end

  // Parser FSM with field capture, drop accounting and the en/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= S_HDR;
      inReady_r       <= 1'b1;
      en_r            <= 1'b0;
      dropPulse_r     <= 1'b0;
      dropCount_r     <= 8'd0;
      chCount_r       <= 8'd0;
      kchIdx_r        <= 8'd0;
      fieldIdx_r      <= 3'd0;
      fPacketType_r   <= 3'd0;
      fSourceID_r     <= {WORD_WIDTH{1'b0}};
      fSourceHops_r   <= {WORD_WIDTH{1'b0}};
      fClusterID_r    <= {WORD_WIDTH{1'b0}};
      fEnergyLeft_r   <= {WORD_WIDTH{1'b0}};
      fQValue_r       <= {WORD_WIDTH{1'b0}};
      fKnownCHCount_r <= {WORD_WIDTH{1'b0}};
      for (int i = 0; i < MAX_KCH; i++) begin
        kchBuf_r[i] <= {WORD_WIDTH{1'b0}};
      end
    end else begin
      en_r        <= 1'b0;
      dropPulse_r <= dropNow_s;
      if (dropNow_s && (dropCount_r != 8'hFF)) begin
        dropCount_r <= dropCount_r + 8'd1;
      end
      case (state_r)
        S_HDR: begin
          if (xfer_s) begin
            fPacketType_r   <= in_data[15:13];
            chCount_r       <= in_data[7:0];
            fKnownCHCount_r <= hdrKchCount_s;
            fieldIdx_r      <= 3'd0;
            kchIdx_r        <= 8'd0;
            state_r         <= in_last ? S_HDR : S_FIELDS;
          end
        end
        S_FIELDS: begin
          if (xfer_s) begin
            case (fieldIdx_r)
              3'd0:    fSourceID_r   <= in_data;
              3'd1:    fSourceHops_r <= in_data;
              3'd2:    fClusterID_r  <= in_data;
              3'd3:    fEnergyLeft_r <= in_data;
              3'd4:    fQValue_r     <= in_data;
              default: fQValue_r     <= fQValue_r;
            endcase
            fieldIdx_r <= fieldIdx_r + 3'd1;
            if (dropNow_s) begin
              state_r <= S_HDR;
            end else if (issueNow_s) begin
              state_r   <= S_ISSUE;
              en_r      <= 1'b1;
              inReady_r <= 1'b0;
            end else if (toFlush_s) begin
              state_r <= S_FLUSH;
            end else if (fieldIdx_r == 3'd4) begin
              state_r <= S_KCH;
            end
          end
        end
        S_KCH: begin
          if (xfer_s) begin
            if (kchStore_s) begin
              kchBuf_r[kchIdx_r[SEL_W-1:0]] <= in_data;
            end
            kchIdx_r <= kchIdx_r + 8'd1;
            if (dropNow_s) begin
              state_r <= S_HDR;
            end else if (issueNow_s) begin
              state_r   <= S_ISSUE;
              en_r      <= 1'b1;
              inReady_r <= 1'b0;
            end else if (toFlush_s) begin
              state_r <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (dropNow_s) begin
            state_r <= S_HDR;
          end else if (issueNow_s) begin
            state_r   <= S_ISSUE;
            en_r      <= 1'b1;
            inReady_r <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            state_r   <= S_HDR;
            inReady_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= S_HDR;
          inReady_r <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = inReady_r;
  assign en            = en_r;
  assign drop_pulse    = dropPulse_r;
  assign drop_count    = dropCount_r;
  assign fPacketType   = fPacketType_r;
  assign fSourceID     = fSourceID_r;
  assign fSourceHops   = fSourceHops_r;
  assign fClusterID    = fClusterID_r;
  assign fEnergyLeft   = fEnergyLeft_r;
  assign fQValue       = fQValue_r;
  assign fKnownCHCount = fKnownCHCount_r;
  assign fKnownCH      = knownCH_s;

endmodule
